// File: rtl/fetch_unit.sv
// Single-issue MIPS fetch stage: PC register, imem req/ack handshake, instruction register.
// Optional retire/stall counters are enabled with the FETCH_CNT_EN macro.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   pc_q;
  logic [31:0]   pc_plus4_q;
  logic [31:0]   instr_q;
  logic          instr_valid_q;
  logic          imem_req_q;

  logic [31:0]   pc_d;
  logic [31:0]   br_off;
  logic [31:0]   jmp_tgt;
  logic          retire_ok;

  // Next-PC resolution: jump beats taken branch beats sequential.
  always_comb begin
    br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jmp_tgt = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    pc_d    = pc_plus4_q;
    if (jump) begin
      pc_d = jmp_tgt;
    end else if (branch && zero) begin
      pc_d = pc_plus4_q + br_off;
    end
  end

  assign retire_ok = (state_q == S_ISSUE) && instr_valid_q && retire && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b1;
          timer_q    <= '0;
        end
        S_REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            timer_q       <= '0;
            state_q       <= S_ISSUE;
          end else if (timer_q == TW'(WAIT_MAX - 1)) begin
            // No ack in time: drop req for one cycle, then re-issue the same address.
            imem_req_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_ISSUE: begin
          if (retire_ok) begin
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_d + 32'd4;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= S_REQ;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          timer_q       <= '0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Retired-instruction and stalled-cycle counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire_ok) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (instr_valid_q && stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
